// File: rtl/kamacore_pipeline_ctrl_if.sv
// ---------------------------------------------------------------------------
// kamacore_pipeline_ctrl_if
//
// Bundles the ID-stage instruction description, the EX-stage status and the
// hazard controls exchanged with kamacore_pipeline_ctrl.
//
// Signals (direction as seen by the controller, i.e. the slave modport):
//   id_valid      in   IF/ID holds a valid instruction
//   id_rs1_a      in   source 1 register address
//   id_rs1_used   in   instruction reads rs1
//   id_rs2_a      in   source 2 register address
//   id_rs2_used   in   instruction reads rs2
//   id_rd_a       in   destination register address
//   id_rd_we      in   instruction writes rd
//   ex_busy       in   EX unit holds its instruction this cycle
//   ex_redirect   in   EX resolved a taken branch/jump this cycle
//   stall_if      out  hold PC and IF/ID buffer
//   stall_id      out  ID instruction not issued this cycle
//   bubble_ex     out  load a NOP into ID/EX
//   flush_if_id   out  clear IF/ID to a NOP
//   issue         out  ID instruction moves to EX at this edge
//   stall_count   out  saturating count of stall_id cycles
//
// Modports:
//   master - pipeline side (drives the instruction/EX status)
//   slave  - hazard controller side
// ---------------------------------------------------------------------------
interface kamacore_pipeline_ctrl_if #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 32
);

  logic                      id_valid;
  logic [REG_ADDR_WIDTH-1:0] id_rs1_a;
  logic                      id_rs1_used;
  logic [REG_ADDR_WIDTH-1:0] id_rs2_a;
  logic                      id_rs2_used;
  logic [REG_ADDR_WIDTH-1:0] id_rd_a;
  logic                      id_rd_we;
  logic                      ex_busy;
  logic                      ex_redirect;

  logic                      stall_if;
  logic                      stall_id;
  logic                      bubble_ex;
  logic                      flush_if_id;
  logic                      issue;
  logic [CNT_WIDTH-1:0]      stall_count;

  modport master (
    output id_valid, id_rs1_a, id_rs1_used, id_rs2_a, id_rs2_used,
           id_rd_a, id_rd_we, ex_busy, ex_redirect,
    input  stall_if, stall_id, bubble_ex, flush_if_id, issue, stall_count
  );

  modport slave (
    input  id_valid, id_rs1_a, id_rs1_used, id_rs2_a, id_rs2_used,
           id_rd_a, id_rd_we, ex_busy, ex_redirect,
    output stall_if, stall_id, bubble_ex, flush_if_id, issue, stall_count
  );

endinterface : kamacore_pipeline_ctrl_if

// File: rtl/kamacore_pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// kamacore_pipeline_ctrl
//
// Hazard and sequencing controller for the 5-stage core. It sits beside the
// ID stage and keeps a scoreboard of in-flight destination registers, one
// slot per stage from EX (slot 0) to WB (slot PIPE_DEPTH-1). From that it
// decides whether the ID instruction may issue, and drives the stall, bubble
// and flush controls of the IF/ID and ID/EX buffers. There is no forwarding,
// so any pending write to a source register stalls ID until it has left WB.
//
// Ports:
//   clk  in   clock
//   rst  in   synchronous reset, active-low
//   bus  slave modport of kamacore_pipeline_ctrl_if (instruction fields,
//        EX status in; stall/bubble/flush/issue/stall_count out)
//
// Parameters:
//   REG_ADDR_WIDTH  register address width
//   PIPE_DEPTH      scoreboard slots between issue and register write (>= 2)
//   CNT_WIDTH       stall counter width
// ---------------------------------------------------------------------------
module kamacore_pipeline_ctrl #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int PIPE_DEPTH     = 3,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  kamacore_pipeline_ctrl_if.slave   bus
);

  if (PIPE_DEPTH < 2) begin : g_depth_check
    $error("kamacore_pipeline_ctrl: PIPE_DEPTH must be at least 2");
  end

  typedef struct packed {
    logic                      pend;
    logic [REG_ADDR_WIDTH-1:0] rd;
  } slot_t;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  slot_t                r_slot [PIPE_DEPTH];
  logic [CNT_WIDTH-1:0] r_stall_count;

  // -------------------------------------------------------------------------
  // Hazard detection
  // -------------------------------------------------------------------------
  logic  w_rs1_hit;
  logic  w_rs2_hit;
  logic  w_raw;
  logic  w_redir;
  logic  w_issue;
  logic  w_stall_id;
  logic  w_bubble_ex;
  logic  w_flush;
  slot_t w_slot0_next;

  // NOTE: every always_comb output gets a default before any conditional
  // update, so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_rs1_hit = 1'b0;
    w_rs2_hit = 1'b0;
    // WB is searched too: the register file has no write-through, so a value
    // being written this cycle is only readable next cycle.
    for (int i = 0; i < PIPE_DEPTH; i++) begin
      if (r_slot[i].pend && (r_slot[i].rd == bus.id_rs1_a)) w_rs1_hit = 1'b1;
      if (r_slot[i].pend && (r_slot[i].rd == bus.id_rs2_a)) w_rs2_hit = 1'b1;
    end
  end

  // x0 is hard-wired to zero, so reading it never depends on anything.
  assign w_raw = bus.id_valid &
                 ((bus.id_rs1_used & (bus.id_rs1_a != '0) & w_rs1_hit) |
                  (bus.id_rs2_used & (bus.id_rs2_a != '0) & w_rs2_hit));

  // A redirect reported while EX is still busy belongs to an instruction
  // that has not finished; only a settled redirect squashes ID.
  assign w_redir = bus.ex_redirect & ~bus.ex_busy;

  // All controls are forced to their idle values while reset is asserted:
  // nothing issues, nothing is flushed and ID/EX is loaded with a NOP.
  assign w_issue     = rst & bus.id_valid & ~w_raw & ~bus.ex_busy & ~w_redir;
  assign w_stall_id  = rst & bus.id_valid & (w_raw | bus.ex_busy) & ~w_redir;
  assign w_flush     = rst & w_redir;
  // When EX is busy, ID/EX must keep its content rather than take a NOP.
  assign w_bubble_ex = ~rst | (~w_issue & ~bus.ex_busy);

  assign bus.issue       = w_issue;
  assign bus.stall_id    = w_stall_id;
  assign bus.stall_if    = w_stall_id;
  assign bus.flush_if_id = w_flush;
  assign bus.bubble_ex   = w_bubble_ex;
  assign bus.stall_count = r_stall_count;

  // Entry entering EX: only a real, non-x0 write ever marks a slot pending.
  always_comb begin
    w_slot0_next = '0;
    if (w_issue) begin
      w_slot0_next.pend = bus.id_rd_we & (bus.id_rd_a != '0);
      w_slot0_next.rd   = bus.id_rd_a;
    end
  end

  // -------------------------------------------------------------------------
  // Scoreboard shift pipeline
  // -------------------------------------------------------------------------
  // NOTE: the scoreboard is a small register array, not a RAM, and every
  // slot is cleared on reset; a stale pending bit after reset would stall
  // the first instructions on a hazard that no longer exists.
  // NOTE: sequential state uses non-blocking assignments so each slot takes
  // the pre-edge value of its neighbour, giving a true one-stage shift.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        r_slot[i] <= '0;
      end
    end else begin
      if (!bus.ex_busy) begin
        r_slot[0] <= w_slot0_next;
        r_slot[1] <= r_slot[0];
      end else begin
        // EX is frozen: its entry stays put and a hole opens behind it while
        // MEM..WB keep draining.
        r_slot[1] <= '0;
      end
      for (int i = 2; i < PIPE_DEPTH; i++) begin
        r_slot[i] <= r_slot[i-1];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Saturating stall-cycle counter
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_stall_count <= '0;
    end else if (w_stall_id && (r_stall_count != '1)) begin
      r_stall_count <= r_stall_count + CNT_WIDTH'(1);
    end
  end

endmodule : kamacore_pipeline_ctrl

// File: doc/kamacore_pipeline_ctrl.md
Name: kamacore_pipeline_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage core.
- Sits beside the ID stage and tracks in-flight destination registers in a scoreboard shift pipeline covering EX..WB.
- Produces stall, bubble and flush controls for the IF/ID and ID/EX stage buffers.
- Handles read-after-write hazards without forwarding, multi-cycle EX occupancy and taken-branch redirects; also keeps a saturating stall-cycle counter.

Parameters:
- REG_ADDR_WIDTH, 5, register address width.
- PIPE_DEPTH, 3, scoreboard slots between ID issue and register-file write (slot 0 = EX, slot PIPE_DEPTH-1 = WB); minimum 2.
- CNT_WIDTH, 32, stall counter width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- id_valid  in  1  IF/ID holds a valid instruction
- id_rs1_a  in  REG_ADDR_WIDTH  source 1 address
- id_rs1_used  in  1  instruction reads rs1
- id_rs2_a  in  REG_ADDR_WIDTH  source 2 address
- id_rs2_used  in  1  instruction reads rs2
- id_rd_a  in  REG_ADDR_WIDTH  destination address
- id_rd_we  in  1  instruction writes rd
- ex_busy  in  1  EX unit holding its instruction this cycle
- ex_redirect  in  1  EX resolved a taken branch/jump this cycle
- stall_if  out  1  hold PC and IF/ID buffer
- stall_id  out  1  ID instruction not issued this cycle
- bubble_ex  out  1  load NOP into ID/EX
- flush_if_id  out  1  clear IF/ID to NOP
- issue  out  1  ID instruction moves to EX at this edge
- stall_count  out  CNT_WIDTH  saturating count of stall_id cycles

Behaviour:
- Scoreboard: PIPE_DEPTH slots, each {pend, rd}.
  - pend is set only when id_rd_we=1 and id_rd_a!=0 at issue.
  - Writes to x0 never create a hazard.
- Effective redirect: redir = ex_redirect & ~ex_busy. ex_redirect while ex_busy=1 is ignored.
- RAW hazard (raw=1) when id_valid=1 and either of:
  - id_rs1_used=1, id_rs1_a!=0, and any slot has pend=1 with rd==id_rs1_a;
  - the same test for rs2.
  - All slots, including WB, are checked: the register file has no write-through, so a WB write becomes visible the following cycle.
- Combinational outputs, valid while rst=1:
  - issue = id_valid & ~raw & ~ex_busy & ~redir
  - stall_id = id_valid & (raw | ex_busy) & ~redir
  - stall_if = stall_id
  - flush_if_id = redir
  - bubble_ex = ~issue & ~ex_busy. Holds ID/EX content when EX is busy.
- Slot update at posedge clk:
  - ex_busy=0: slot0 <= issue ? {id_rd_we & (id_rd_a!=0), id_rd_a} : {0,0}; slot[i] <= slot[i-1] for i>=1.
  - ex_busy=1: slot0 holds; slot1 <= {0,0}; slot[i] <= slot[i-1] for i>=2. Downstream drains while EX is frozen.
- Redirect squashes the ID instruction: no issue, bubble_ex=1, flush_if_id=1, stall_if=0 so the PC loads the target. Redirect takes priority over raw.
- stall_count increments by 1 at each edge where stall_id=1, and saturates at all-ones with no wrap.
- Reset (rst=0 at posedge) clears all slots and stall_count to 0, including mid-stall or mid-busy.
- While rst=0: stall_if=0, stall_id=0, issue=0, flush_if_id=0, bubble_ex=1.
- Latency: a dependent instruction directly behind its producer stalls exactly PIPE_DEPTH cycles, then issues.

Test Plan:
- Reset: hold rst=0 for 2 cycles with arbitrary inputs -> stall_count=0, bubble_ex=1, all other outputs 0. Release -> scoreboard empty, and an independent instruction issues on the first cycle.
- Back-to-back RAW: issue "add x1" (rd=1, we=1); next cycle present rs1=1 -> stall_id=stall_if=1, bubble_ex=1 for 3 cycles, issue=1 on the 4th; stall_count=3.
- x0 and unused sources:
  - Producer rd=0 with we=1, then consumer rs1=0 -> no stall.
  - Producer rd=5, then consumer with rs2_a=5 but rs2_used=0 -> no stall.
- ex_busy: hold ex_busy=1 for 2 cycles with an independent ID instruction -> stall_id=1 and bubble_ex=0 both cycles; slot0 held while an older entry drains from WB; issue on the cycle ex_busy drops.
- Redirect during RAW stall: on the 2nd stall cycle assert ex_redirect=1 -> flush_if_id=1, bubble_ex=1, stall_if=0, issue=0, stall_count unchanged. Same cycle with ex_busy=1 -> redirect ignored.
- Saturation: with CNT_WIDTH=4, hold a RAW stall by re-presenting the dependency for 20 cycles -> stall_count reaches 15 and stays there. Then rst=0 -> stall_count returns to 0.
